// File: rtl/id_gen.sv
// id_gen: identifier token generator.
// Emits ASCII identifiers one character per accepted handshake: one or more
// lowercase letters, then zero or more digits, then the SEP_CHAR separator.
// Letter and digit indices run on across tokens (a..z, 0..9, wrapping) and
// are cleared only by reset.
//
// Optional feature macro: ID_GEN_UPPER_EN
//   When defined, an extra input `upper` is latched together with start.
//   Tokens started with upper=1 use uppercase letters ('A'..'Z').
//   When undefined, there is no `upper` port and letters are always lowercase.
//
// Handshake (output side): char/valid form a valid/ready source. A character
// transfers on a rising clk edge where valid && ready are both high. While
// valid is high and ready is low, char and valid hold their values unchanged.
// After a transfer the next character is presented in the very next cycle,
// so characters stream back-to-back while ready stays high.
//
// state_dbg mirrors the FSM state encoding (IDLE=0, LETTERS=1, DIGITS=2,
// SEP=3) for observation only.

module id_gen #(
  parameter logic [7:0] SEP_CHAR = 8'h20,
  parameter int         CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_letters,
  input  logic [CNT_W-1:0] n_digits,
`ifdef ID_GEN_UPPER_EN
  input  logic             upper,
`endif
  input  logic             ready,
  output logic [7:0]       char,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LETTERS = 2'd1,
    DIGITS  = 2'd2,
    SEP     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [4:0]       letter_idx;
  logic [3:0]       digit_idx;
  logic [CNT_W-1:0] let_rem;
  logic [CNT_W-1:0] dig_rem;
  logic             up_q;
  logic             up_in;
  logic             xfer;

  // Case selection for letters: only the configured build can request uppercase.
`ifdef ID_GEN_UPPER_EN
  assign up_in = upper;
`else
  assign up_in = 1'b0;
`endif

  // A character leaves the block on every edge where both sides agree.
  assign xfer = valid && ready;

  assign state_dbg = state;

  // ASCII letter for a 0..25 index, upper- or lowercase.
  function automatic logic [7:0] letter_char(input logic [4:0] idx, input logic up);
    logic [7:0] base;
    base = up ? 8'h41 : 8'h61;
    return base + {3'b000, idx};
  endfunction

  // ASCII digit for a 0..9 index.
  function automatic logic [7:0] digit_char(input logic [3:0] idx);
    return 8'h30 + {4'b0000, idx};
  endfunction

  // Letter index advances z -> a.
  function automatic logic [4:0] letter_next(input logic [4:0] idx);
    return (idx == 5'd25) ? 5'd0 : idx + 5'd1;
  endfunction

  // Digit index advances 9 -> 0.
  function automatic logic [3:0] digit_next(input logic [3:0] idx);
    return (idx == 4'd9) ? 4'd0 : idx + 4'd1;
  endfunction

  // Token FSM: all outputs are registered and computed one cycle ahead so the
  // next character is already on char when the current one transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      char       <= 8'h00;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      letter_idx <= 5'd0;
      digit_idx  <= 4'd0;
      let_rem    <= CNT_ZERO;
      dig_rem    <= CNT_ZERO;
      up_q       <= 1'b0;
    end else begin
      // done and err are single-cycle pulses.
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (n_letters != CNT_ZERO) begin
              let_rem <= n_letters;
              dig_rem <= n_digits;
              up_q    <= up_in;
              state   <= LETTERS;
              busy    <= 1'b1;
              valid   <= 1'b1;
              // First letter uses the case being latched right now.
              char    <= letter_char(letter_idx, up_in);
            end else begin
              // An identifier needs at least one letter; refuse the request.
              err <= 1'b1;
            end
          end
        end

        LETTERS: begin
          if (xfer) begin
            letter_idx <= letter_next(letter_idx);
            let_rem    <= let_rem - CNT_ONE;
            if (let_rem == CNT_ONE) begin
              // Last letter just went out: digits if any, else the separator.
              if (dig_rem != CNT_ZERO) begin
                state <= DIGITS;
                char  <= digit_char(digit_idx);
              end else begin
                state <= SEP;
                char  <= SEP_CHAR;
              end
            end else begin
              char <= letter_char(letter_next(letter_idx), up_q);
            end
          end
        end

        DIGITS: begin
          if (xfer) begin
            digit_idx <= digit_next(digit_idx);
            dig_rem   <= dig_rem - CNT_ONE;
            if (dig_rem == CNT_ONE) begin
              state <= SEP;
              char  <= SEP_CHAR;
            end else begin
              char <= digit_char(digit_next(digit_idx));
            end
          end
        end

        SEP: begin
          if (xfer) begin
            // Token complete: drop valid and signal done for one cycle.
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
